fp_sub_iter: RTL and testbench

//  Multi-cycle IEEE-754 single-precision subtractor: Result = Number1 - Number2.

---
 rtl/fp_sub_iter.sv | 158 +++++++++++++++
 tb/tb_fp_sub_iter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fp_sub_iter.sv
// Multi-cycle single-precision subtractor: Result = Number1 - Number2.
// Alignment and renormalisation move one bit per cycle. Rounding is by truncation.
//
// state | meaning
// IDLE  | waiting for _go; operands captured on an accepted pulse
// ALIGN | shift the smaller mantissa right once per cycle until cnt == 0
// ADD   | add or subtract the magnitudes; handle zero sum and carry-out
// NORM  | shift left until the hidden bit is set, or flush on underflow
// DONE  | one-cycle done pulse; Result was written on entry
module fp_sub_iter #(
    parameter int MAX_ALIGN = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        _go,
    input  logic [31:0] Number1,
    input  logic [31:0] Number2,
    output logic [31:0] Result,
    output logic        done,
    output logic        busy
);
    localparam logic [7:0] MAX_ALIGN_W = 8'(MAX_ALIGN);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    state_t      state, state_nxt;
    logic [23:0] m_l, m_s;
    logic        sign_l, sign_s;
    logic [7:0]  exp_r;
    logic [4:0]  cnt;
    logic [24:0] sum;
    logic        sign_r;

    logic [7:0]  e1, e2;
    logic        special;
    logic [24:0] add_sum;
    logic        add_sign;

    assign e1      = Number1[30:23];
    assign e2      = Number2[30:23];
    assign special = (e1 == 8'hFF) || (e2 == 8'hFF) || (e1 == 8'h00) || (e2 == 8'h00);

    // Magnitude add/subtract of the aligned mantissas; the larger magnitude sets the sign
    always_comb begin
        add_sum  = '0;
        add_sign = sign_l;
        if (sign_l == sign_s) begin
            add_sum  = {1'b0, m_l} + {1'b0, m_s};
            add_sign = sign_l;
        end else if (m_l >= m_s) begin
            add_sum  = {1'b0, m_l} - {1'b0, m_s};
            add_sign = sign_l;
        end else begin
            add_sum  = {1'b0, m_s} - {1'b0, m_l};
            add_sign = sign_s;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (_go) state_nxt = special ? DONE : ALIGN;
            end
            ALIGN: if (cnt == 5'd0) state_nxt = ADD;
            ADD: begin
                if (add_sum == 25'd0)                    state_nxt = DONE;
                else if (add_sum[24] && exp_r == 8'hFE)  state_nxt = DONE;
                else                                     state_nxt = NORM;
            end
            NORM: if (sum[23] || exp_r <= 8'd1) state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, shifting, and the Result register
    always_ff @(posedge clk) begin
        if (reset) begin
            Result <= 32'h0;
            m_l    <= '0;
            m_s    <= '0;
            sign_l <= 1'b0;
            sign_s <= 1'b0;
            exp_r  <= '0;
            cnt    <= '0;
            sum    <= '0;
            sign_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (_go) begin
                    if (e1 == 8'hFF || e2 == 8'hFF)
                        Result <= 32'h7FC0_0000;
                    else if (e1 == 8'h00 && e2 == 8'h00)
                        Result <= 32'h0;
                    else if (e1 == 8'h00)
                        Result <= {~Number2[31], Number2[30:0]};
                    else if (e2 == 8'h00)
                        Result <= Number1;
                    else if (e1 >= e2) begin
                        m_l    <= {1'b1, Number1[22:0]};
                        sign_l <= Number1[31];
                        m_s    <= {1'b1, Number2[22:0]};
                        sign_s <= ~Number2[31];
                        exp_r  <= e1;
                        cnt    <= ((e1 - e2) > MAX_ALIGN_W) ? MAX_ALIGN_W[4:0] : 5'(e1 - e2);
                    end else begin
                        m_l    <= {1'b1, Number2[22:0]};
                        sign_l <= ~Number2[31];
                        m_s    <= {1'b1, Number1[22:0]};
                        sign_s <= Number1[31];
                        exp_r  <= e2;
                        cnt    <= ((e2 - e1) > MAX_ALIGN_W) ? MAX_ALIGN_W[4:0] : 5'(e2 - e1);
                    end
                end
                ALIGN: if (cnt != 5'd0) begin
                    m_s <= m_s >> 1;
                    cnt <= cnt - 5'd1;
                end
                ADD: begin
                    sign_r <= add_sign;
                    if (add_sum == 25'd0)
                        Result <= 32'h0;
                    else if (add_sum[24]) begin
                        sum   <= add_sum >> 1;
                        exp_r <= exp_r + 8'd1;
                        if (exp_r == 8'hFE) Result <= {add_sign, 8'hFF, 23'h0};
                    end else
                        sum <= add_sum;
                end
                NORM: begin
                    if (sum[23])
                        Result <= {sign_r, exp_r, sum[22:0]};
                    else if (exp_r <= 8'd1)
                        Result <= 32'h0;
                    else begin
                        sum   <= sum << 1;
                        exp_r <= exp_r - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_sub_iter.sv
// Bench for fp_sub_iter: directed corner cases plus random operands against
// an arithmetic reference model of the subtraction and its cycle latency.
module tb_fp_sub_iter;
    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic [31:0] n1, n2;
    logic [31:0] result;
    logic        done, busy;

    int n_checks = 0;
    int n_fail   = 0;

    fp_sub_iter dut (
        .clk     (clk),
        .reset   (reset),
        ._go     (go),
        .Number1 (n1),
        .Number2 (n2),
        .Result  (result),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: decode, align with a plain shift, add integers, normalise in a loop.
    // lat is the number of cycles from the accepting edge to the done cycle.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output int lat);
        int e1, e2, el, d, c, e, l;
        longint ml, ms, s;
        logic sa, sb, sl, ss, sg;
        e1 = int'(a[30:23]);
        e2 = int'(b[30:23]);
        sa = a[31];
        sb = ~b[31];
        lat = 1;
        r = 32'h0;
        if (e1 == 255 || e2 == 255) r = 32'h7FC00000;
        else if (e1 == 0 && e2 == 0) r = 32'h0;
        else if (e1 == 0) r = {sb, b[30:0]};
        else if (e2 == 0) r = a;
        else begin
            if (e1 >= e2) begin
                el = e1; d = e1 - e2; sl = sa; ss = sb;
                ml = longint'({1'b1, a[22:0]}); ms = longint'({1'b1, b[22:0]});
            end else begin
                el = e2; d = e2 - e1; sl = sb; ss = sa;
                ml = longint'({1'b1, b[22:0]}); ms = longint'({1'b1, a[22:0]});
            end
            c  = (d > 25) ? 25 : d;
            ms = ms >> c;
            if (sl == ss)      begin s = ml + ms; sg = sl; end
            else if (ml >= ms) begin s = ml - ms; sg = sl; end
            else               begin s = ms - ml; sg = ss; end
            e = el;
            l = 0;
            if (s == 0) begin
                r = 32'h0; lat = c + 3;
            end else begin
                if (s >= (64'd1 << 24)) begin
                    s = s >> 1; e = e + 1;
                end
                if (e == 255) begin
                    r = {sg, 8'hFF, 23'h0}; lat = c + 3;
                end else begin
                    while (s < (64'd1 << 23) && e > 1) begin
                        s = s << 1; e = e - 1; l++;
                    end
                    if (s >= (64'd1 << 23)) r = {sg, 8'(e), s[22:0]};
                    else                    r = 32'h0;
                    lat = c + l + 4;
                end
            end
        end
    endfunction

    // Launch one operation, scramble inputs and pulse _go while busy, then check
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input int exp_lat, input string tag);
        int n;
        bit got;
        n = 0;
        got = 0;
        @(negedge clk);
        go = 1'b1; n1 = a; n2 = b;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            n++;
            if (done) begin
                got = 1;
                go = 1'b0;
                break;
            end
            check({tag, ".busy"}, 32'(busy), 32'd1);
            go = 1'($urandom_range(0, 1));
            n1 = $urandom;
            n2 = $urandom;
        end
        check({tag, ".done_seen"}, 32'(got), 32'd1);
        check({tag, ".latency"}, 32'(n), 32'(exp_lat));
        check({tag, ".result"}, result, exp_r);
        @(negedge clk);
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check({tag, ".single_done"}, 32'(done), 32'd0);
    endtask

    task automatic run_model(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] r;
        int lat;
        model(a, b, r, lat);
        run_op(a, b, r, lat, tag);
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        int sel;
        v = $urandom;
        sel = $urandom_range(0, 19);
        if (sel == 0)      v[30:23] = 8'h00;
        else if (sel == 1) v[30:23] = 8'hFF;
        else if (sel == 2) v[30:23] = 8'(1 + $urandom_range(0, 3));
        else if (sel == 3) v[30:23] = 8'(250 + $urandom_range(0, 4));
        else               v[30:23] = 8'(120 + $urandom_range(0, 30));
        return v;
    endfunction

    initial begin
        logic [31:0] a, b;
        reset = 1'b1; go = 1'b0; n1 = '0; n2 = '0;
        repeat (3) @(negedge clk);
        check("rst.result", result, 32'h0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(32'h40400000, 32'h3F800000, 32'h40000000, 5,  "3m1");
        run_op(32'h3F800000, 32'h3FC00000, 32'hBF000000, 5,  "1m1p5");
        run_op(32'h3F800000, 32'hBF800000, 32'h40000000, 4,  "carry");
        run_op(32'h3FC00000, 32'h3FC00000, 32'h00000000, 3,  "zero");
        run_op(32'h4C000000, 32'h3F800000, 32'h4C000000, 29, "cap25");
        run_op(32'h7F800000, 32'h3F800000, 32'h7FC00000, 1,  "inf");
        run_op(32'h3F800000, 32'h7FC00001, 32'h7FC00000, 1,  "nan2");
        run_op(32'h00000000, 32'h80000000, 32'h00000000, 1,  "bothz");
        run_op(32'h00000005, 32'h3F800000, 32'hBF800000, 1,  "ftz1");
        run_op(32'hC0000000, 32'h00001234, 32'hC0000000, 1,  "ftz2");
        run_op(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 3,  "ovf");
        run_op(32'h00800001, 32'h00800000, 32'h00000000, 4,  "uflow");

        for (int i = 0; i < 250; i++) begin
            a = rand_fp();
            b = rand_fp();
            if ($urandom_range(0, 7) == 0) b = a;
            else if ($urandom_range(0, 7) == 0) b = {~a[31], a[30:0]};
            run_model(a, b, "rnd");
        end

        @(negedge clk);
        go = 1'b1; n1 = 32'h4C000000; n2 = 32'h3F800000;
        @(negedge clk);
        go = 1'b0;
        repeat (4) @(negedge clk);
        check("abort.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.result", result, 32'h0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) check("abort.no_done", 32'(done), 32'd0);
        end
        check("abort.idle", 32'(busy), 32'd0);

        run_op(32'h40400000, 32'h3F800000, 32'h40000000, 5, "post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
